// File: rtl/xalu_ctrl.sv
// Issue controller for the HI/LO multiply/divide unit: captures E-stage requests,
// presents them one cycle later, tracks unit latency and stalls D on HI/LO hazards.
module xalu_ctrl #(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        d_md_use,
  input  logic        xalu_busy,
  output logic        xalu_start,
  output logic [2:0]  xalu_op,
  output logic [31:0] xalu_a,
  output logic [31:0] xalu_b,
  output logic        stall_d,
  output logic        md_busy,
  output logic        issue_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b111;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [3:0] MUL_CNT = 4'(MUL_CYC);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        err_q, err_d;

  // True for mult/multu/div/divu, the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // True only for mthi/mtlo; other upper encodings are never forwarded to the unit.
  function automatic logic is_move_op(input logic [2:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // State, counter, latched request and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_NOP;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and the combinational START/op presented in PEND.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q | (e_valid & (state_q != S_IDLE));
    xalu_start = 1'b0;
    xalu_op    = OP_NOP;
    case (state_q)
      S_IDLE: begin
        if (e_valid) begin
          op_d    = e_op;
          a_d     = e_a;
          b_d     = e_b;
          state_d = S_PEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PEND: begin
        state_d = S_IDLE;
        if (IntReq) begin
          xalu_op = OP_NOP;
        end else if (is_long_op(op_q)) begin
          xalu_start = 1'b1;
          xalu_op    = op_q;
          state_d    = S_RUN;
          cnt_d      = op_q[1] ? DIV_CNT : MUL_CNT;
        end else if (is_move_op(op_q)) begin
          xalu_op = op_q;
        end else begin
          xalu_op = OP_NOP;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        // Counter alone ends RUN; xalu_busy only feeds the stall.
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign xalu_a    = a_q;
  assign xalu_b    = b_q;
  assign md_busy   = (state_q != S_IDLE);
  assign issue_err = err_q;
  // Deliberately independent of xalu_start to avoid a loop through the unit.
  assign stall_d   = d_md_use & (e_valid | (state_q != S_IDLE) | xalu_busy);

endmodule

// File: tb/tb_xalu_ctrl.sv
// Scoreboard bench for xalu_ctrl: a cycle-count reference model predicts busy/stall/error
// and unit transactions; a negedge monitor compares; a small HI/LO unit model closes the loop.
module tb_xalu_ctrl;
  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, IntReq, e_valid, d_md_use, xalu_busy, busy_x;
  logic [2:0]  e_op;
  logic [31:0] e_a, e_b;
  logic        xalu_start, stall_d, md_busy, issue_err;
  logic [2:0]  xalu_op;
  logic [31:0] xalu_a, xalu_b;

  xalu_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .IntReq(IntReq), .e_valid(e_valid), .e_op(e_op),
    .e_a(e_a), .e_b(e_b), .d_md_use(d_md_use), .xalu_busy(xalu_busy),
    .xalu_start(xalu_start), .xalu_op(xalu_op), .xalu_a(xalu_a), .xalu_b(xalu_b),
    .stall_d(stall_d), .md_busy(md_busy), .issue_err(issue_err)
  );

  typedef struct { int cyc; logic busy; logic stall; logic err; } cyc_exp_t;
  typedef struct { int cyc; logic start; logic [2:0] op; logic [31:0] a; logic [31:0] b; } txn_t;

  cyc_exp_t cq[$];
  txn_t     tq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: cycle at which the controller is free again, and the PEND cycle.
  int          free_at = 0;
  int          pend_at = -1;
  logic [2:0]  m_op = 3'b111;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_err = 1'b0;

  // Behavioural HI/LO unit.
  int          ucnt = 0;
  logic [31:0] u_hi = 32'd0, u_lo = 32'd0;
  assign xalu_busy = (ucnt != 0) | busy_x;

  function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b000: begin p = sa * sb; return p; end
      3'b001: return ua * ub;
      3'b010: return (b == 32'd0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      3'b011: return (b == 32'd0) ? 64'd0 : {32'(ua % ub), 32'(ua / ub)};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ucnt <= 0;
    end else if (xalu_start) begin
      ucnt <= xalu_op[1] ? DIV_CYC : MUL_CYC;
      {u_hi, u_lo} <= unit_calc(xalu_op, xalu_a, xalu_b);
    end else begin
      if (ucnt > 0) ucnt <= ucnt - 1;
      if (xalu_op == 3'b100) u_hi <= xalu_a;
      else if (xalu_op == 3'b101) u_lo <= xalu_a;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs, record expectations from the model, advance the model.
  task automatic step(input logic ev, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic irq, input logic duse, input logic rst, input logic bx);
    cyc_exp_t ce;
    txn_t     t;
    logic     busy_now;
    e_valid = ev; e_op = op; e_a = a; e_b = b;
    IntReq = irq; d_md_use = duse; reset = rst; busy_x = bx;
    busy_now = (ucnt != 0) | bx;
    ce.cyc   = cyc;
    ce.busy  = (cyc < free_at);
    ce.stall = duse & (ev | ce.busy | busy_now);
    ce.err   = m_err;
    cq.push_back(ce);
    if (cyc == pend_at && !irq) begin
      t.cyc = cyc; t.op = m_op; t.a = m_a; t.b = m_b;
      if (m_op <= 3'd3) begin
        t.start = 1'b1;
        tq.push_back(t);
        free_at = cyc + 1 + ((m_op >= 3'd2) ? DIV_CYC : MUL_CYC);
      end else if (m_op == 3'd4 || m_op == 3'd5) begin
        t.start = 1'b0;
        tq.push_back(t);
      end
    end
    if (rst) begin
      free_at = cyc + 1;
      pend_at = -1;
      m_err   = 1'b0;
    end else if (ev) begin
      if (ce.busy) begin
        m_err = 1'b1;
      end else begin
        pend_at = cyc + 1;
        free_at = cyc + 2;
        m_op = op; m_a = a; m_b = b;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic duse, input logic irq);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, irq, duse, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle status checks and transaction scoreboard.
  always @(negedge clk) begin
    cyc_exp_t ce;
    txn_t     t;
    logic     presenting;
    if (cq.size() > 0) begin
      ce = cq.pop_front();
      chk("md_busy", {31'd0, md_busy}, {31'd0, ce.busy});
      chk("stall_d", {31'd0, stall_d}, {31'd0, ce.stall});
      chk("issue_err", {31'd0, issue_err}, {31'd0, ce.err});
      presenting = (xalu_start !== 1'b0) || (xalu_op !== 3'b111);
      if (tq.size() > 0 && tq[0].cyc == ce.cyc) begin
        t = tq.pop_front();
        chk("txn_start", {31'd0, xalu_start}, {31'd0, t.start});
        chk("txn_op", {29'd0, xalu_op}, {29'd0, t.op});
        chk("txn_a", xalu_a, t.a);
        if (t.start) chk("txn_b", xalu_b, t.b);
      end else if (presenting) begin
        total++;
        bad++;
        $display("FAIL spurious_issue cyc=%0d got start=%b op=%b want start=0 op=111", ce.cyc, xalu_start, xalu_op);
      end
    end
  end

  logic [31:0] sv_hi, sv_lo;
  logic        rnd_rst;

  initial begin
    reset = 1'b1; IntReq = 1'b0; e_valid = 1'b0; e_op = 3'd0; e_a = 32'd0; e_b = 32'd0;
    d_md_use = 1'b0; busy_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_xalu_a", xalu_a, 32'd0);
    chk("rst_xalu_b", xalu_b, 32'd0);
    chk("rst_xalu_op", {29'd0, xalu_op}, 32'd7);
    chk("rst_start", {31'd0, xalu_start}, 32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_issue_err", {31'd0, issue_err}, 32'd0);
    chk("rst_stall", {31'd0, stall_d}, 32'd0);
    idle(2, 1'b0, 1'b0);

    // mult -2 * 3 with d_md_use held high
    step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1, 1'b0);
    chk("mult_hi", u_hi, 32'hFFFF_FFFF);
    chk("mult_lo", u_lo, 32'hFFFF_FFFA);
    idle(2, 1'b1, 1'b0);

    // divu 100 / 7
    step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0, 1'b0);
    chk("divu_hi", u_hi, 32'd2);
    chk("divu_lo", u_lo, 32'd14);
    idle(1, 1'b0, 1'b0);

    // mthi
    step(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    chk("mthi_hi", u_hi, 32'h1234_5678);
    idle(2, 1'b0, 1'b0);

    // div cancelled by IntReq in PEND
    sv_hi = u_hi; sv_lo = u_lo;
    step(1'b1, 3'd2, 32'd50, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);
    chk("div_irq_hi", u_hi, sv_hi);
    chk("div_irq_lo", u_lo, sv_lo);

    // mtlo cancelled by IntReq
    sv_lo = u_lo;
    step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b0);
    chk("mtlo_irq_lo", u_lo, sv_lo);

    // reset in cycle 3 of a div
    step(1'b1, 3'd2, 32'd77, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);

    // request during RUN sets the sticky error without disturbing RUN timing
    step(1'b1, 3'd0, 32'd6, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    step(1'b1, 3'd3, 32'd9, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1, 1'b0);
    chk("err_sticky", {31'd0, issue_err}, 32'd1);
    chk("mult_after_err_lo", u_lo, 32'd42);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rnd_rst = (cyc != pend_at) && ($urandom_range(0, 79) == 0);
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 5)), $urandom, $urandom,
           $urandom_range(0, 3) == 0, 1'($urandom), rnd_rst, $urandom_range(0, 7) == 0);
    end
    idle(14, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("txn_queue_drained", tq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
